// File: rtl/io_cmd_sched.sv
// G-15 I/O command scheduler: grants auto > cpu > panel and launches the code at T0.
// Latency: gnt is combinational in IDLE; io_start follows the first T0 seen in ARM by one cycle.
// Backpressure: requests are levels and are only sampled in IDLE while READY=1.
module io_cmd_sched #(
  parameter int          ACK_WAIT  = 64,
  parameter int          TIMEOUT_W = 20,
  parameter logic [3:0]  AUTO_CODE = 4'b1111
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       T0,
  input  logic       READY,
  input  logic       req_auto,
  input  logic       req_cpu,
  input  logic [3:0] cpu_code,
  input  logic       req_panel,
  input  logic [3:0] panel_code,
  output logic [2:0] gnt,
  output logic [3:0] io_code,
  output logic       io_start,
  output logic       io_clear,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int ACK_CW = $clog2(ACK_WAIT + 1);
  localparam int CW     = (TIMEOUT_W > ACK_CW) ? TIMEOUT_W : ACK_CW;
  localparam logic [CW-1:0] ACK_LIM = CW'(ACK_WAIT);
  localparam logic [CW-1:0] ACT_LIM = CW'((64'd1 << TIMEOUT_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ISSUE, S_ACK, S_ACTIVE, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          code_ld;
  logic [3:0]    code_n;
  logic          fail;
  logic          abort_cpu, abort_pnl;

  assign abort_cpu = req_cpu   && (cpu_code   == 4'b0000);
  assign abort_pnl = req_panel && (panel_code == 4'b0000);
  assign busy      = (state != S_IDLE);

  // Outputs are gated by rst so a held request cannot leak a grant while reset is asserted.
  always_comb begin
    state_n  = state;
    gnt      = 3'b000;
    io_start = 1'b0;
    io_clear = 1'b0;
    done     = 1'b0;
    code_ld  = 1'b0;
    code_n   = io_code;
    fail     = 1'b0;
    cnt_clr  = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (READY) begin
            if (req_auto) begin
              gnt = 3'b001; code_n = AUTO_CODE; code_ld = 1'b1; state_n = S_ARM;
            end else if (req_cpu) begin
              gnt = 3'b010; code_n = cpu_code; code_ld = 1'b1; state_n = S_ARM;
            end else if (req_panel) begin
              gnt = 3'b100; code_n = panel_code; code_ld = 1'b1; state_n = S_ARM;
            end
          end
        end
        S_ARM: begin
          if (T0) state_n = S_ISSUE;
        end
        S_ISSUE: begin
          io_start = 1'b1;
          cnt_clr  = 1'b1;
          state_n  = (io_code == 4'b0000) ? S_DONE : S_ACK;
        end
        S_ACK, S_ACTIVE: begin
          if (abort_cpu || abort_pnl) begin
            // A set-ready request aborts the running command and completes itself.
            gnt      = abort_cpu ? 3'b010 : 3'b100;
            code_n   = 4'b0000;
            code_ld  = 1'b1;
            io_clear = 1'b1;
            done     = 1'b1;
            state_n  = S_IDLE;
          end else if (state == S_ACK) begin
            if (!READY) begin
              cnt_clr = 1'b1;
              state_n = S_ACTIVE;
            end else if (cnt >= ACK_LIM) begin
              io_clear = 1'b1; fail = 1'b1; state_n = S_IDLE;
            end
          end else begin
            if (READY) begin
              state_n = S_DONE;
            end else if (cnt >= ACT_LIM) begin
              io_clear = 1'b1; fail = 1'b1; state_n = S_IDLE;
            end
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      io_code <= 4'b0000;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (code_ld) io_code <= code_n;
      if (fail)          timeout <= 1'b1;
      else if (|gnt)     timeout <= 1'b0;
      // Watchdog saturates rather than wrapping so a stuck compare can never be skipped.
      if (cnt_clr)
        cnt <= '0;
      else if ((state == S_ACK || state == S_ACTIVE) && (cnt != {CW{1'b1}}))
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_io_cmd_sched.sv
// Directed bench for io_cmd_sched: default instance plus a TIMEOUT_W=4 instance for the active watchdog.
module tb_io_cmd_sched;

  logic       CLOCK, rst, T0, READY;
  logic       req_auto, req_cpu, req_panel;
  logic [3:0] cpu_code, panel_code;
  logic [2:0] gnt;
  logic [3:0] io_code;
  logic       io_start, io_clear, busy, done, timeout;

  logic       ready2, req_cpu2;
  logic [3:0] cpu_code2;
  logic [2:0] gnt2;
  logic [3:0] io_code2;
  logic       io_start2, io_clear2, busy2, done2, timeout2;

  int n_checks = 0;
  int n_err    = 0;

  io_cmd_sched dut (
    .CLOCK(CLOCK), .rst(rst), .T0(T0), .READY(READY),
    .req_auto(req_auto), .req_cpu(req_cpu), .cpu_code(cpu_code),
    .req_panel(req_panel), .panel_code(panel_code),
    .gnt(gnt), .io_code(io_code), .io_start(io_start), .io_clear(io_clear),
    .busy(busy), .done(done), .timeout(timeout)
  );

  io_cmd_sched #(.TIMEOUT_W(4)) dut_t4 (
    .CLOCK(CLOCK), .rst(rst), .T0(T0), .READY(ready2),
    .req_auto(1'b0), .req_cpu(req_cpu2), .cpu_code(cpu_code2),
    .req_panel(1'b0), .panel_code(4'b0000),
    .gnt(gnt2), .io_code(io_code2), .io_start(io_start2), .io_clear(io_clear2),
    .busy(busy2), .done(done2), .timeout(timeout2)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLOCK);
    #1;
  endtask

  // Runs one command from the cycle after its grant: T0 at once, quick ack and completion.
  task automatic fast_cmd(input logic [2:0] drop, input logic [3:0] code);
    nxt();
    if (drop[0]) req_auto  = 1'b0;
    if (drop[1]) req_cpu   = 1'b0;
    if (drop[2]) req_panel = 1'b0;
    T0 = 1'b1; #1;
    chk("arm_code", 32'(io_code), 32'(code));
    chk("arm_gnt", 32'(gnt), 32'd0);
    nxt(); T0 = 1'b0; #1;
    chk("fc_start", 32'(io_start), 32'd1);
    chk("fc_start_code", 32'(io_code), 32'(code));
    nxt(); READY = 1'b0; #1;
    chk("fc_ack_busy", 32'(busy), 32'd1);
    nxt(); READY = 1'b1; #1;
    chk("fc_active_done", 32'(done), 32'd0);
    nxt(); #1;
    chk("fc_done", 32'(done), 32'd1);
    chk("fc_done_gnt", 32'(gnt), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; T0 = 1'b0; READY = 1'b1;
    req_auto = 1'b0; req_cpu = 1'b0; req_panel = 1'b0;
    cpu_code = 4'b0000; panel_code = 4'b0000;
    ready2 = 1'b1; req_cpu2 = 1'b0; cpu_code2 = 4'b0000;
    repeat (2) @(posedge CLOCK);
    #1;
    // Reset values, with a request held to show the grant is suppressed.
    req_cpu = 1'b1; cpu_code = 4'b0110; #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_io_code", 32'(io_code), 32'd0);
    chk("rst_io_start", 32'(io_start), 32'd0);
    chk("rst_io_clear", 32'(io_clear), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    req_cpu = 1'b0;
    rst = 1'b0;

    // CPU only: T0 five cycles after gnt, READY low 3 cycles after io_start for 100 cycles.
    nxt(); req_cpu = 1'b1; cpu_code = 4'b0110; #1;
    chk("cpu_gnt", 32'(gnt), 32'b010);
    chk("cpu_gnt_busy", 32'(busy), 32'd0);
    nxt(); req_cpu = 1'b0; #1;
    chk("cpu_arm_busy", 32'(busy), 32'd1);
    chk("cpu_arm_code", 32'(io_code), 32'b0110);
    chk("cpu_arm_gnt", 32'(gnt), 32'd0);
    repeat (3) begin
      nxt(); #1;
      chk("cpu_arm_nostart", 32'(io_start), 32'd0);
    end
    nxt(); T0 = 1'b1; #1;
    chk("cpu_t0_nostart", 32'(io_start), 32'd0);
    nxt(); T0 = 1'b0; #1;
    chk("cpu_start", 32'(io_start), 32'd1);
    chk("cpu_start_code", 32'(io_code), 32'b0110);
    nxt(); #1;
    chk("cpu_start_pulse", 32'(io_start), 32'd0);
    nxt();
    nxt(); READY = 1'b0;
    repeat (99) nxt();
    nxt(); READY = 1'b1; #1;
    chk("cpu_pre_done", 32'(done), 32'd0);
    nxt(); #1;
    chk("cpu_done", 32'(done), 32'd1);
    chk("cpu_done_busy", 32'(busy), 32'd1);
    nxt(); #1;
    chk("cpu_after_done", 32'(done), 32'd0);
    chk("cpu_after_busy", 32'(busy), 32'd0);

    // Simultaneous requests: auto, then cpu, then panel.
    nxt(); req_auto = 1'b1; req_cpu = 1'b1; cpu_code = 4'b0011;
    req_panel = 1'b1; panel_code = 4'b0101; #1;
    chk("sim_gnt_auto", 32'(gnt), 32'b001);
    fast_cmd(3'b001, 4'b1111);
    nxt(); #1;
    chk("sim_gnt_cpu", 32'(gnt), 32'b010);
    fast_cmd(3'b010, 4'b0011);
    nxt(); #1;
    chk("sim_gnt_panel", 32'(gnt), 32'b100);
    fast_cmd(3'b100, 4'b0101);
    nxt(); #1;
    chk("sim_idle_gnt", 32'(gnt), 32'd0);
    chk("sim_idle_busy", 32'(busy), 32'd0);

    // No acknowledge: READY stays 1 through the whole ACK window.
    nxt(); req_cpu = 1'b1; cpu_code = 4'b0111; #1;
    chk("noack_gnt", 32'(gnt), 32'b010);
    nxt(); req_cpu = 1'b0; T0 = 1'b1; #1;
    nxt(); T0 = 1'b0; #1;
    chk("noack_start", 32'(io_start), 32'd1);
    for (int k = 0; k < 64; k++) begin
      nxt(); #1;
      chk("noack_wait_clear", 32'(io_clear), 32'd0);
      chk("noack_wait_done", 32'(done), 32'd0);
    end
    nxt(); #1;
    chk("noack_clear", 32'(io_clear), 32'd1);
    chk("noack_clear_done", 32'(done), 32'd0);
    nxt(); #1;
    chk("noack_timeout", 32'(timeout), 32'd1);
    chk("noack_clear_pulse", 32'(io_clear), 32'd0);
    chk("noack_idle", 32'(busy), 32'd0);
    // Set-ready command from the panel: grant clears timeout, ISSUE goes straight to DONE.
    nxt(); req_panel = 1'b1; panel_code = 4'b0000; #1;
    chk("sr_gnt", 32'(gnt), 32'b100);
    chk("sr_timeout_still", 32'(timeout), 32'd1);
    nxt(); req_panel = 1'b0; T0 = 1'b1; #1;
    chk("sr_timeout_clr", 32'(timeout), 32'd0);
    nxt(); T0 = 1'b0; #1;
    chk("sr_start", 32'(io_start), 32'd1);
    chk("sr_code", 32'(io_code), 32'd0);
    nxt(); #1;
    chk("sr_done", 32'(done), 32'd1);
    nxt(); #1;
    chk("sr_idle", 32'(busy), 32'd0);

    // Abort during ACTIVE; T0 in the grant cycle must be ignored.
    nxt(); req_cpu = 1'b1; cpu_code = 4'b1001; T0 = 1'b1; #1;
    chk("ab_gnt", 32'(gnt), 32'b010);
    nxt(); req_cpu = 1'b0; T0 = 1'b0; #1;
    chk("ab_t0_ignored", 32'(io_start), 32'd0);
    nxt(); T0 = 1'b1; #1;
    chk("ab_arm_nostart", 32'(io_start), 32'd0);
    nxt(); T0 = 1'b0; #1;
    chk("ab_start", 32'(io_start), 32'd1);
    nxt(); READY = 1'b0;
    nxt(); #1;
    chk("ab_active_busy", 32'(busy), 32'd1);
    nxt(); req_panel = 1'b1; panel_code = 4'b0000; req_cpu = 1'b1; cpu_code = 4'b0100; #1;
    chk("ab_clear", 32'(io_clear), 32'd1);
    chk("ab_gnt_panel", 32'(gnt), 32'b100);
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_timeout", 32'(timeout), 32'd0);
    nxt(); req_panel = 1'b0; #1;
    chk("ab_idle", 32'(busy), 32'd0);
    chk("ab_ready0_nogrant", 32'(gnt), 32'd0);
    nxt(); READY = 1'b1; #1;
    chk("ab_pending_cpu", 32'(gnt), 32'b010);

    // Reset in the middle of the pending CPU command's ACTIVE phase.
    nxt(); req_cpu = 1'b0; T0 = 1'b1;
    nxt(); T0 = 1'b0; #1;
    chk("rm_start", 32'(io_start), 32'd1);
    chk("rm_code", 32'(io_code), 32'b0100);
    nxt(); READY = 1'b0;
    nxt(); #1;
    chk("rm_active", 32'(busy), 32'd1);
    nxt(); req_cpu = 1'b1; cpu_code = 4'b0010; #1;
    chk("rm_no_abort", 32'(gnt), 32'd0);
    rst = 1'b1; #1;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_io_code", 32'(io_code), 32'd0);
    chk("rm_io_start", 32'(io_start), 32'd0);
    chk("rm_io_clear", 32'(io_clear), 32'd0);
    chk("rm_done", 32'(done), 32'd0);
    chk("rm_timeout", 32'(timeout), 32'd0);
    READY = 1'b1; #1;
    chk("rm_gnt_held", 32'(gnt), 32'd0);
    nxt(); #1;
    chk("rm_gnt_held2", 32'(gnt), 32'd0);
    chk("rm_io_clear2", 32'(io_clear), 32'd0);
    rst = 1'b0; #1;
    chk("rm_regrant", 32'(gnt), 32'b010);
    nxt(); req_cpu = 1'b0; #1;
    chk("rm_regrant_code", 32'(io_code), 32'b0010);
    chk("rm_regrant_busy", 32'(busy), 32'd1);

    // Active-phase watchdog on the TIMEOUT_W=4 instance (limit 15).
    nxt(); req_cpu2 = 1'b1; cpu_code2 = 4'b1010; #1;
    chk("at_gnt", 32'(gnt2), 32'b010);
    nxt(); req_cpu2 = 1'b0; T0 = 1'b1; #1;
    nxt(); T0 = 1'b0; #1;
    chk("at_start", 32'(io_start2), 32'd1);
    chk("at_code", 32'(io_code2), 32'b1010);
    nxt(); ready2 = 1'b0; #1;
    chk("at_ack_busy", 32'(busy2), 32'd1);
    for (int k = 0; k < 15; k++) begin
      nxt(); #1;
      chk("at_wait_clear", 32'(io_clear2), 32'd0);
      chk("at_wait_done", 32'(done2), 32'd0);
    end
    nxt(); #1;
    chk("at_clear", 32'(io_clear2), 32'd1);
    chk("at_clear_done", 32'(done2), 32'd0);
    chk("at_clear_timeout", 32'(timeout2), 32'd0);
    nxt(); #1;
    chk("at_timeout", 32'(timeout2), 32'd1);
    chk("at_idle", 32'(busy2), 32'd0);
    chk("at_clear_pulse", 32'(io_clear2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
